// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch (I)
// and load/store (D) ports; one full request/ack handshake per transaction.
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ack_ph_q, ack_ph_d;
  logic [3:0]        wmask_hold_q, wmask_hold_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              mem_rstrb_q, mem_rstrb_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              winner;
  logic [3:0]        win_mask;

  // On a tie the port that did not win last time is served.
  function automatic logic pick_winner(input logic ireq, input logic dreq,
                                       input logic last);
    if (ireq && dreq) return ~last;
    return dreq ? PORT_D : PORT_I;
  endfunction

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    ack_ph_d     = ack_ph_q;
    wmask_hold_d = wmask_hold_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = 4'h0;
    mem_rstrb_d  = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    winner       = PORT_I;
    win_mask     = 4'h0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          winner       = pick_winner(i_req, d_req, last_grant_q);
          gnt_d        = winner;
          last_grant_d = winner;
          if (winner == PORT_D) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            win_mask    = d_wmask;
          end else begin
            mem_addr_d  = i_addr;
            mem_wdata_d = 32'h0;
            win_mask    = 4'h0;
          end
          wmask_hold_d = win_mask;
          // Strobes are registered, so they are raised here to be live in ISSUE.
          mem_rstrb_d  = (win_mask == 4'h0);
          mem_wmask_d  = win_mask;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d    = LAT_M1;
        ack_ph_d = 1'b0;
        state_d  = (LAT_M1 == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        if (!ack_ph_q) begin
          // First RESP cycle: mem_rdata is valid now; capture and schedule ack.
          ack_ph_d = 1'b1;
          if (gnt_q == PORT_D) begin
            d_ack_d = 1'b1;
            if (wmask_hold_q == 4'h0) d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else begin
          ack_ph_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      gnt_q        <= PORT_I;
      cnt_q        <= 4'd0;
      ack_ph_q     <= 1'b0;
      wmask_hold_q <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_wmask_q  <= 4'h0;
      mem_rstrb_q  <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      ack_ph_q     <= ack_ph_d;
      wmask_hold_q <= wmask_hold_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_rstrb_q  <= mem_rstrb_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_rstrb = mem_rstrb_q;
  assign busy      = busy_q;

  // Structural invariants of the handshake.
  a_ack_onehot: assert property (@(posedge CLK) disable iff (RESET)
    !(i_ack_q && d_ack_q));
  a_strobe_excl: assert property (@(posedge CLK) disable iff (RESET)
    !(mem_rstrb_q && (mem_wmask_q != 4'h0)));
  a_strobe_issue: assert property (@(posedge CLK) disable iff (RESET)
    (mem_rstrb_q || (mem_wmask_q != 4'h0)) |-> (state_q == ISSUE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at LATENCY=1, one at LATENCY=4,
// each backed by a small fixed-latency memory model.
module tb_mem_arbiter;

  logic        CLK;
  logic        RESET;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wmask;

  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_wmask1;
  logic        i_ack1, d_ack1, mem_rstrb1, busy1;
  logic [31:0] i_rdata4, d_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic [3:0]  mem_wmask4;
  logic        i_ack4, d_ack4, mem_rstrb4, busy4;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mem_arbiter #(.LATENCY(1), .ADDR_W(32)) u_dut1 (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1),
    .mem_rstrb(mem_rstrb1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_arbiter #(.LATENCY(4), .ADDR_W(32)) u_dut4 (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata4), .i_ack(i_ack4),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata4), .d_ack(d_ack4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_wmask(mem_wmask4),
    .mem_rstrb(mem_rstrb4), .mem_rdata(mem_rdata4), .busy(busy4)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory models: data is valid only in the cycle ISSUE+LATENCY.
  logic [3:0]  pend1, pend4;
  logic [31:0] raddr1, raddr4;

  always @(posedge CLK) begin
    if (RESET) pend1 <= 4'd0;
    else if (mem_rstrb1) begin pend1 <= 4'd1; raddr1 <= mem_addr1; end
    else if (pend1 != 4'd0) pend1 <= pend1 - 4'd1;
  end
  always @(posedge CLK) begin
    if (RESET) pend4 <= 4'd0;
    else if (mem_rstrb4) begin pend4 <= 4'd4; raddr4 <= mem_addr4; end
    else if (pend4 != 4'd0) pend4 <= pend4 - 4'd1;
  end
  assign mem_rdata1 = (pend1 == 4'd1) ? memval(raddr1) : 32'hBAD0BAD0;
  assign mem_rdata4 = (pend4 == 4'd1) ? memval(raddr4) : 32'hBAD0BAD0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Leaves the bench at cycle 0: #1 after the last reset edge, DUTs in IDLE.
  task automatic do_reset();
    RESET = 1'b1; i_req = 1'b0; d_req = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++;
    if ({i_ack1, d_ack1, busy1, mem_rstrb1, mem_wmask1} !== 8'h0) begin
      err_cnt++;
      $display("FAIL reset_ctrl1 got %b exp 0", {i_ack1, d_ack1, busy1, mem_rstrb1, mem_wmask1});
    end
    cmp_cnt++;
    if ({mem_addr1, mem_wdata1, i_rdata1, d_rdata1} !== 128'h0) begin
      err_cnt++;
      $display("FAIL reset_data1 got %h exp 0", {mem_addr1, mem_wdata1, i_rdata1, d_rdata1});
    end
    cmp_cnt++;
    if ({i_ack4, d_ack4, busy4, mem_rstrb4, mem_wmask4, mem_addr4, i_rdata4, d_rdata4} !== 104'h0) begin
      err_cnt++;
      $display("FAIL reset_dut4 got %h exp 0", {i_ack4, d_ack4, busy4, mem_rstrb4, mem_wmask4, mem_addr4});
    end
  endtask

  task automatic test_lone_fetch();
    logic [3:0] exp, got;
    do_reset();
    i_req = 1'b1; i_addr = 32'h10;
    for (int n = 1; n <= 5; n++) begin
      @(posedge CLK); #1;
      exp = {n == 1, n == 3, 1'b0, (n >= 1) && (n <= 3)};
      got = {mem_rstrb1, i_ack1, d_ack1, busy1};
      cmp_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL fetch_ctrl cyc %0d got %b exp %b", n, got, exp);
      end
      if (n == 1) begin
        cmp_cnt++;
        if (mem_addr1 !== 32'h10) begin
          err_cnt++;
          $display("FAIL fetch_addr got %h exp 00000010", mem_addr1);
        end
      end
      if (n == 3) begin
        cmp_cnt++;
        if (i_rdata1 !== 32'hDEADBEEF) begin
          err_cnt++;
          $display("FAIL fetch_rdata got %h exp deadbeef", i_rdata1);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    logic       seen;
    logic [6:0] exp, got;
    do_reset();
    d_req = 1'b1; d_addr = 32'h20; d_wmask = 4'h0;
    seen = 1'b0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(posedge CLK); #1;
      if (d_ack1) seen = 1'b1;
    end
    cmp_cnt++;
    if (!seen) begin
      err_cnt++;
      $display("FAIL load_ack_timeout got no d_ack exp d_ack within 10 cycles");
    end
    cmp_cnt++;
    if (d_rdata1 !== memval(32'h20)) begin
      err_cnt++;
      $display("FAIL load_rdata got %h exp %h", d_rdata1, memval(32'h20));
    end
    d_req = 1'b0;
    @(posedge CLK); #1;
    d_req = 1'b1; d_addr = 32'h400; d_wdata = 32'h0000000F; d_wmask = 4'hF;
    for (int n = 1; n <= 4; n++) begin
      @(posedge CLK); #1;
      exp = {1'b0, (n == 1) ? 4'hF : 4'h0, 1'b0, n == 3};
      got = {mem_rstrb1, mem_wmask1, i_ack1, d_ack1};
      cmp_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL store_ctrl cyc %0d got %b exp %b", n, got, exp);
      end
      if (n == 1) begin
        cmp_cnt++;
        if ({mem_addr1, mem_wdata1} !== {32'h400, 32'h0000000F}) begin
          err_cnt++;
          $display("FAIL store_bus got %h/%h exp 00000400/0000000f", mem_addr1, mem_wdata1);
        end
      end
      if (n == 3) begin
        cmp_cnt++;
        if (d_rdata1 !== memval(32'h20)) begin
          err_cnt++;
          $display("FAIL store_rdata_kept got %h exp %h", d_rdata1, memval(32'h20));
        end
        d_req = 1'b0; d_wmask = 4'h0;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp, got;
    do_reset();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_wmask = 4'h0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge CLK); #1;
      exp = {(n % 4) == 1, n == 3 || n == 11, n == 7 || n == 15};
      got = {mem_rstrb1, i_ack1, d_ack1};
      cmp_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL rr_ctrl cyc %0d got %b exp %b", n, got, exp);
      end
      if ((n % 4) == 1) begin
        cmp_cnt++;
        if (mem_addr1 !== ((n == 1) ? 32'h100 : (n == 9) ? 32'h104 : 32'h200)) begin
          err_cnt++;
          $display("FAIL rr_addr cyc %0d got %h", n, mem_addr1);
        end
      end
      if (n == 3) begin
        cmp_cnt++;
        if (i_rdata1 !== memval(32'h100)) begin
          err_cnt++;
          $display("FAIL rr_irdata1 got %h exp %h", i_rdata1, memval(32'h100));
        end
        i_addr = 32'h104;
      end
      if (n == 7) begin
        cmp_cnt++;
        if ({d_rdata1, i_rdata1} !== {memval(32'h200), memval(32'h100)}) begin
          err_cnt++;
          $display("FAIL rr_drdata got %h/%h exp %h/%h", d_rdata1, i_rdata1, memval(32'h200), memval(32'h100));
        end
      end
      if (n == 11) begin
        cmp_cnt++;
        if (i_rdata1 !== memval(32'h104)) begin
          err_cnt++;
          $display("FAIL rr_irdata2 got %h exp %h", i_rdata1, memval(32'h104));
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_latency4();
    logic [2:0] exp, got;
    do_reset();
    i_req = 1'b1; i_addr = 32'h40;
    for (int n = 1; n <= 8; n++) begin
      @(posedge CLK); #1;
      exp = {n == 1, n == 6, n <= 6};
      got = {mem_rstrb4, i_ack4, busy4};
      cmp_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL lat4_ctrl cyc %0d got %b exp %b", n, got, exp);
      end
      if (n <= 6) begin
        cmp_cnt++;
        if (mem_addr4 !== 32'h40) begin
          err_cnt++;
          $display("FAIL lat4_addr cyc %0d got %h exp 00000040", n, mem_addr4);
        end
      end
      if (n == 6) begin
        cmp_cnt++;
        if (i_rdata4 !== memval(32'h40)) begin
          err_cnt++;
          $display("FAIL lat4_rdata got %h exp %h", i_rdata4, memval(32'h40));
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1'b1; d_addr = 32'h80; d_wmask = 4'h0;
    for (int n = 1; n <= 3; n++) begin
      @(posedge CLK); #1;
      cmp_cnt++;
      if ({d_ack4, busy4} !== 2'b01) begin
        err_cnt++;
        $display("FAIL midrst_pre cyc %0d got %b exp 01", n, {d_ack4, busy4});
      end
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    cmp_cnt++;
    if ({i_ack4, d_ack4, busy4, mem_rstrb4, mem_wmask4, mem_addr4, mem_wdata4, d_rdata4} !== 104'h0) begin
      err_cnt++;
      $display("FAIL midrst_outs got %h exp 0", {i_ack4, d_ack4, busy4, mem_rstrb4, mem_wmask4, mem_addr4});
    end
    RESET = 1'b0; i_req = 1'b1; i_addr = 32'h44;
    for (int n = 1; n <= 6; n++) begin
      @(posedge CLK); #1;
      cmp_cnt++;
      if ({d_ack4, i_ack4} !== {1'b0, n == 6}) begin
        err_cnt++;
        $display("FAIL midrst_acks cyc %0d got %b exp %b", n, {d_ack4, i_ack4}, {1'b0, n == 6});
      end
      if (n == 1) begin
        cmp_cnt++;
        if ({mem_rstrb4, mem_addr4} !== {1'b1, 32'h44}) begin
          err_cnt++;
          $display("FAIL midrst_grant got %b/%h exp 1/00000044", mem_rstrb4, mem_addr4);
        end
      end
      if (n == 6) begin
        cmp_cnt++;
        if (i_rdata4 !== memval(32'h44)) begin
          err_cnt++;
          $display("FAIL midrst_rdata got %h exp %h", i_rdata4, memval(32'h44));
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp, got;
    do_reset();
    i_req = 1'b1; i_addr = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge CLK); #1;
      exp = {n == 1 || n == 5, n == 3 || n == 7, 1'b0};
      got = {mem_rstrb1, i_ack1, d_ack1};
      cmp_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("FAIL b2b_ctrl cyc %0d got %b exp %b", n, got, exp);
      end
      if (n == 5) begin
        cmp_cnt++;
        if (mem_addr1 !== 32'h4) begin
          err_cnt++;
          $display("FAIL b2b_addr got %h exp 00000004", mem_addr1);
        end
      end
      if (n == 3) i_addr = 32'h4;
      if (n == 7) begin
        cmp_cnt++;
        if ({i_rdata1, d_rdata1} !== {memval(32'h4), 32'h0}) begin
          err_cnt++;
          $display("FAIL b2b_rdata got %h/%h exp %h/00000000", i_rdata1, d_rdata1, memval(32'h4));
        end
        i_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store();
    test_round_robin();
    test_latency4();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
